// File: rtl/core_inst_queue.sv
// core_inst_queue
//   Instruction queue between fetch F2 and decode. Takes up to two fetched
//   instructions per cycle, compacts them into a circular buffer and presents
//   up to two in-order instructions per cycle to decode.
//
//   Optional feature macro: INST_QUEUE_BYPASS_EN
//     When defined, an empty queue forwards the incoming pair straight to the
//     outputs in the same cycle; slots consumed that cycle are not stored.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   flush_i        discard all contents; same-cycle push/pop ignored
//   valid_i[1:0]   per-slot valid from fetch
//   inst_i[2]      instruction words (slot k at {pc_i[31:3], k, 2'b00})
//   pc_i           fetch pair PC
//   attached_i     BPU info, copied to both slots
//   stall_req_o    registered early stall toward fetch
//   valid_o[1:0]   thermometer output valid (00/01/11)
//   inst_o/pc_o/attached_o  head and head+1 entries
//   ready_i[1:0]   thermometer consume from decode (10 treated as 00)
//   overflow_o     sticky: a push exceeded free space (reset clears)
module core_inst_queue #(
   parameter int ATTACHED_INFO_WIDTH = 32,
   parameter int DEPTH               = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush_i,
   input  logic [1:0]                          valid_i,
   input  logic [1:0][31:0]                    inst_i,
   input  logic [31:0]                         pc_i,
   input  logic [ATTACHED_INFO_WIDTH-1:0]      attached_i,
   output logic                                stall_req_o,
   output logic [1:0]                          valid_o,
   output logic [1:0][31:0]                    inst_o,
   output logic [1:0][31:0]                    pc_o,
   output logic [1:0][ATTACHED_INFO_WIDTH-1:0] attached_o,
   input  logic [1:0]                          ready_i,
   output logic                                overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]                    mem_inst [DEPTH];
   logic [31:0]                    mem_pc   [DEPTH];
   logic [ATTACHED_INFO_WIDTH-1:0] mem_att  [DEPTH];

   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;

   // compacted view of the incoming pair
   logic [1:0][31:0] c_inst, c_pc;
   logic [1:0]       np;

   logic [AW-1:0] rd1;
   logic          bypass;
   logic [1:0]    nq, sk, pend, wr_cnt, rd_adv;
   logic [CW-1:0] free, cnt_next;
   logic          ovf_now;

   logic          we0, we1;
   logic [31:0]   wd0_inst, wd0_pc;
   logic [AW-1:0] wa0, wa1;

   always_comb begin
      c_inst[1] = inst_i[1];
      c_pc[1]   = {pc_i[31:3], 3'b100};
      c_inst[0] = valid_i[0] ? inst_i[0] : inst_i[1];
      c_pc[0]   = valid_i[0] ? {pc_i[31:3], 3'b000} : {pc_i[31:3], 3'b100};
      np        = {1'b0, valid_i[0]} + {1'b0, valid_i[1]};
   end

`ifdef INST_QUEUE_BYPASS_EN
   assign bypass = (cnt_q == '0) && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   // output mux: stored head pair, or the incoming pair when bypassing
   always_comb begin
      rd1           = rd_q + AW'(1);
      valid_o       = {cnt_q >= CW'(2), cnt_q != '0};
      inst_o[0]     = mem_inst[rd_q];
      inst_o[1]     = mem_inst[rd1];
      pc_o[0]       = mem_pc[rd_q];
      pc_o[1]       = mem_pc[rd1];
      attached_o[0] = mem_att[rd_q];
      attached_o[1] = mem_att[rd1];
      if (bypass) begin
         valid_o       = {np[1], np != 2'd0};
         inst_o        = c_inst;
         pc_o          = c_pc;
         attached_o[0] = attached_i;
         attached_o[1] = attached_i;
      end
   end

   // pop / push accounting; a 10 ready pattern consumes nothing
   always_comb begin
      nq       = {1'b0, valid_o[0] & ready_i[0]} +
                 {1'b0, valid_o[1] & ready_i[1] & ready_i[0]};
      // bypassed slots that decode takes this cycle are never stored
      sk       = bypass ? nq : 2'd0;
      rd_adv   = bypass ? 2'd0 : nq;
      pend     = np - sk;
      free     = CW'(DEPTH) - cnt_q + CW'(rd_adv);
      ovf_now  = CW'(pend) > free;
      wr_cnt   = ovf_now ? free[1:0] : pend;
      cnt_next = cnt_q + CW'(wr_cnt) - CW'(rd_adv);
   end

   always_comb begin
      we0      = rst_n && !flush_i && (wr_cnt != 2'd0);
      we1      = rst_n && !flush_i && (wr_cnt == 2'd2);
      wa0      = wr_q;
      wa1      = wr_q + AW'(1);
      wd0_inst = sk[0] ? c_inst[1] : c_inst[0];
      wd0_pc   = sk[0] ? c_pc[1]   : c_pc[0];
   end

   // storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (we0) begin
         mem_inst[wa0] <= wd0_inst;
         mem_pc[wa0]   <= wd0_pc;
         mem_att[wa0]  <= attached_i;
      end
      if (we1) begin
         mem_inst[wa1] <= c_inst[1];
         mem_pc[wa1]   <= c_pc[1];
         mem_att[wa1]  <= attached_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q        <= '0;
         wr_q        <= '0;
         cnt_q       <= '0;
         stall_req_o <= 1'b0;
         overflow_o  <= 1'b0;
      end else if (flush_i) begin
         rd_q        <= '0;
         wr_q        <= '0;
         cnt_q       <= '0;
         stall_req_o <= 1'b0;
      end else begin
         rd_q        <= rd_q + AW'(rd_adv);
         wr_q        <= wr_q + AW'(wr_cnt);
         cnt_q       <= cnt_next;
         // early stall: fetch may still land one more pair after this rises
         stall_req_o <= cnt_next > CW'(DEPTH - 4);
         if (ovf_now) overflow_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_core_inst_queue.sv
module tb_core_inst_queue;

   localparam int AIW   = 32;
   localparam int DEPTH = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush_i;
   logic [1:0]            valid_i;
   logic [1:0][31:0]      inst_i;
   logic [31:0]           pc_i;
   logic [AIW-1:0]        attached_i;
   logic                  stall_req_o;
   logic [1:0]            valid_o;
   logic [1:0][31:0]      inst_o;
   logic [1:0][31:0]      pc_o;
   logic [1:0][AIW-1:0]   attached_o;
   logic [1:0]            ready_i;
   logic                  overflow_o;

   core_inst_queue #(.ATTACHED_INFO_WIDTH(AIW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i),
      .inst_i(inst_i), .pc_i(pc_i), .attached_i(attached_i),
      .stall_req_o(stall_req_o), .valid_o(valid_o), .inst_o(inst_o),
      .pc_o(pc_o), .attached_o(attached_o), .ready_i(ready_i),
      .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]    inst;
      logic [31:0]    pc;
      logic [AIW-1:0] att;
   } ent_t;

   // reference model: an in-order list of entries plus pointer arithmetic
   ent_t q[$];
   int   m_rd, m_wr;
   bit   m_stall, m_ovf;
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      flush_i = 1'b1;
      valid_i = 2'b00;
      ready_i = 2'b00;
      inst_i  = '0;
      pc_i    = '0;
      attached_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      q.delete();
      m_rd = 0; m_wr = 0; m_stall = 0; m_ovf = 0;
      rst_n   = 1'b1;
      flush_i = 1'b0;
   endtask

   // one clock: drive, check outputs against the model, then advance the model
   task automatic cycle(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] pc, input logic [31:0] att,
                        input logic [1:0] rdy, input logic fl);
      ent_t p[$];
      ent_t view[$];
      ent_t e;
      int   nq;
      logic [1:0] exp_v;
      bit   byp;
      valid_i = v; inst_i[0] = i0; inst_i[1] = i1; pc_i = pc; attached_i = att;
      ready_i = rdy; flush_i = fl;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (v[k]) begin
            e.inst = (k == 0) ? i0 : i1;
            e.pc   = {pc[31:3], 3'b000} + 32'(4 * k);
            e.att  = att;
            p.push_back(e);
         end
      end
      byp = 0;
`ifdef INST_QUEUE_BYPASS_EN
      byp = (q.size() == 0) && !fl;
`endif
      view = byp ? p : q;
      exp_v = (view.size() >= 2) ? 2'b11 : (view.size() == 1) ? 2'b01 : 2'b00;
      chk("valid_o", 64'(valid_o), 64'(exp_v));
      chk("stall_req_o", 64'(stall_req_o), 64'(m_stall));
      chk("overflow_o", 64'(overflow_o), 64'(m_ovf));
      chk("cnt", 64'(dut.cnt_q), 64'(q.size()));
      chk("rd_ptr", 64'(dut.rd_q), 64'(m_rd));
      for (int j = 0; j < 2; j++) begin
         if (j < view.size()) begin
            chk($sformatf("inst_o[%0d]", j), 64'(inst_o[j]), 64'(view[j].inst));
            chk($sformatf("pc_o[%0d]", j), 64'(pc_o[j]), 64'(view[j].pc));
            chk($sformatf("attached_o[%0d]", j), 64'(attached_o[j]), 64'(view[j].att));
         end
      end
      if (fl) begin
         q.delete();
         m_rd = 0; m_wr = 0; m_stall = 0;
      end else begin
         nq = (rdy == 2'b11) ? exp_v[0] + exp_v[1] : (rdy == 2'b01) ? int'(exp_v[0]) : 0;
         if (byp) begin
            repeat (nq) void'(p.pop_front());
         end else begin
            repeat (nq) void'(q.pop_front());
            m_rd = (m_rd + nq) % DEPTH;
         end
         foreach (p[k]) begin
            if (q.size() < DEPTH) begin
               q.push_back(p[k]);
               m_wr = (m_wr + 1) % DEPTH;
            end else begin
               m_ovf = 1;
            end
         end
         m_stall = q.size() > DEPTH - 4;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic [1:0] rdy, input logic fl);
      cycle(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, rdy, fl);
   endtask

   initial begin
      logic [1:0] rv, rr;
      int seq;
      seq = 0;
      rst_n = 1'b0;
      @(negedge clk);
      do_reset();
      idle(2'b00, 1'b0);

      // pair push, then lone slot-1 push
      cycle(2'b11, 32'hA, 32'hB, 32'h1c000000, 32'h11, 2'b00, 1'b0);
      idle(2'b11, 1'b0);
      cycle(2'b10, 32'hDEAD, 32'hC, 32'h1c000008, 32'h22, 2'b00, 1'b0);
      idle(2'b01, 1'b0);

      // move rd pointer to 6
      cycle(2'b11, 32'h100, 32'h101, 32'h1c000010, 32'h33, 2'b00, 1'b0);
      cycle(2'b01, 32'h102, 32'h0, 32'h1c000018, 32'h34, 2'b00, 1'b0);
      idle(2'b11, 1'b0);
      idle(2'b01, 1'b0);

      // fill to 7, then sustained push/pop across the wrap
      for (int k = 0; k < 3; k++)
         cycle(2'b11, 32'h200 + 32'(2*k), 32'h201 + 32'(2*k), 32'h1c000100 + 32'(8*k), 32'h40 + 32'(k), 2'b00, 1'b0);
      cycle(2'b01, 32'h206, 32'h0, 32'h1c000200, 32'h44, 2'b00, 1'b0);
      for (int k = 0; k < 10; k++)
         cycle(2'b11, 32'h300 + 32'(2*k), 32'h301 + 32'(2*k), 32'h1c000300 + 32'(8*k), 32'h50 + 32'(k), 2'b11, 1'b0);

      // flush with a same-cycle push, then a fresh push lands at index 0
      idle(2'b11, 1'b0);
      cycle(2'b11, 32'h400, 32'h401, 32'h1c000400, 32'h60, 2'b00, 1'b1);
      cycle(2'b11, 32'h402, 32'h403, 32'h1c000408, 32'h61, 2'b00, 1'b0);
      idle(2'b00, 1'b0);

`ifdef INST_QUEUE_BYPASS_EN
      idle(2'b00, 1'b1);
      cycle(2'b11, 32'hD, 32'hE, 32'h1c000500, 32'h70, 2'b01, 1'b0);
      idle(2'b00, 1'b0);
      idle(2'b11, 1'b0);
`endif

      // random traffic; fetch honours the stall request
      for (int k = 0; k < 400; k++) begin
         rv = m_stall ? 2'b00 : 2'($urandom_range(0, 3));
         rr = 2'($urandom_range(0, 3));
         seq += 2;
         cycle(rv, $urandom, $urandom, {$urandom} & 32'hffff_fff8, $urandom, rr,
               ($urandom_range(0, 19) == 0));
      end

      // full queue, pop2+push2 while full, then overflow
      idle(2'b00, 1'b1);
      for (int k = 0; k < 4; k++)
         cycle(2'b11, 32'h600 + 32'(2*k), 32'h601 + 32'(2*k), 32'h1c000600 + 32'(8*k), 32'h80 + 32'(k), 2'b00, 1'b0);
      cycle(2'b11, 32'h610, 32'h611, 32'h1c000700, 32'h90, 2'b11, 1'b0);
      cycle(2'b11, 32'h612, 32'h613, 32'h1c000708, 32'h91, 2'b00, 1'b0);
      idle(2'b00, 1'b0);
      idle(2'b00, 1'b1);
      idle(2'b00, 1'b0);
      do_reset();
      idle(2'b00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
